dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter READ_LAT, default 1, meaning DRAM clock cycles from address issue to valid dram_dout (legal range 1..7).
REQ-002 clk  input  1  system clock (divided core clock); all state updates on rising edge.
REQ-003 rst  input  1  asynchronous reset, active high.
REQ-004 cpu_req  input  1  CPU (memory-register path) access request, held until cpu_ack.
REQ-005 cpu_we  input  1  CPU request type: 1 write, 0 read.
REQ-006 cpu_addr  input  17  CPU byte address.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_ack  output  1  one-cycle pulse: CPU request issued to DRAM.
REQ-009 cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid.
REQ-010 cpu_rdata  output  8  CPU read data.
REQ-011 dma_req, dma_we, dma_addr[16:0], dma_wdata[7:0] inputs; dma_ack, dma_rvalid, dma_rdata[7:0] outputs; same meanings for the UART image-load DMA port.
REQ-012 dram_addr  output  17  DRAM address.
REQ-013 dram_we  output  1  DRAM write enable.
REQ-014 dram_din  output  8  DRAM write data.
REQ-015 dram_dout  input  8  DRAM read data.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 owner  output  1  current/last grantee: 0 CPU, 1 DMA.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-019 IDLE: if any req high, select grantee, capture its we/addr/wdata into internal registers, set owner, go ISSUE; else stay IDLE.
REQ-020 Arbitration SHALL be round-robin: priority pointer favours CPU after reset; after each grant pointer moves to the non-granted port; with one requester, it wins regardless of pointer.
REQ-021 ISSUE: dram_addr/dram_din from captured registers, dram_we = captured we for exactly this cycle, grantee ack = 1 for exactly this cycle; write -> IDLE, read -> WAIT with counter loaded to READ_LAT.
REQ-022 WAIT: dram_addr held, dram_we = 0, counter decrements each cycle; in the cycle counter equals 1, dram_dout SHALL be latched into grantee rdata and FSM goes IDLE.
REQ-023 Grantee rvalid SHALL pulse for one cycle in the IDLE cycle following the latch (read latency ack-to-rvalid = READ_LAT+1 cycles); IDLE may capture a new request in that same cycle.
REQ-024 Non-grantee rdata SHALL hold its previous value; rvalid/ack never asserted to non-grantee.
REQ-025 dram_addr and dram_din SHALL hold last issued values while IDLE; dram_we SHALL be 0 outside ISSUE.
REQ-026 Requests captured in IDLE SHALL complete even if req deasserts afterwards; req still high in IDLE after its ack SHALL be treated as a new request.
REQ-027 Throughput: write 2 cycles/access, read READ_LAT+2 cycles/access; with both ports continuously requesting, grants SHALL alternate CPU, DMA, CPU, ...
REQ-028 No combinational path from any req input to dram_we or ack outputs.

Reset
REQ-029 On rst high (any state, including mid-transaction): state IDLE, pointer CPU, owner 0, dram_we 0, dram_addr 0, dram_din 0, all ack/rvalid 0, both rdata 0, busy 0; aborted transaction produces no ack or rvalid.
REQ-030 dram_we SHALL drop in the same cycle rst asserts (asynchronous).

Verification
REQ-031 CPU write addr 0x1ABCD data 0x5A, DMA idle -> ack in 2nd cycle, dram_we high one cycle with addr 0x1ABCD din 0x5A, busy 2 cycles.
REQ-032 CPU read of 0x00010 (memory model holds 0xC3, READ_LAT=1) -> cpu_ack cycle N, cpu_rvalid cycle N+2, cpu_rdata 0xC3.
REQ-033 Both ports request writes same cycle after reset -> CPU granted first, DMA next; sustained requests alternate strictly, owner toggles.
REQ-034 READ_LAT=3, DMA read -> dma_rvalid exactly 4 cycles after dma_ack; dram_addr stable throughout WAIT.
REQ-035 rst asserted during WAIT of CPU read -> no cpu_rvalid, all outputs zero, next request after release granted to CPU.
REQ-036 Requester keeps req high after ack -> second access issued, confirming REQ-026.

Source files
------------

// File: rtl/dram_arbiter_if.sv
// Purpose: signal bundle for dram_arbiter. Carries the CPU and DMA request
// ports, the DRAM-side bus and the status outputs.
// Modports:
//   slave  - arbiter side (takes requests, drives the DRAM bus and status)
//   master - environment side (requesters plus the DRAM read-data return)
interface dram_arbiter_if;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;

  // CPU (memory-register path) port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  // UART image-load DMA port
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  // DRAM side
  logic [ADDR_W-1:0] dram_addr;
  logic              dram_we;
  logic [DATA_W-1:0] dram_din;
  logic [DATA_W-1:0] dram_dout;

  // status
  logic              busy;
  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rvalid, dma_rdata,
    output dram_addr, dram_we, dram_din,
    input  dram_dout,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rvalid, dma_rdata,
    input  dram_addr, dram_we, dram_din,
    output dram_dout,
    input  busy, owner
  );
endinterface

// File: rtl/dram_arbiter.sv
// Purpose: round-robin arbiter sharing one DRAM between the CPU and the
// UART image-load DMA. One access at a time: IDLE picks a grantee, ISSUE
// drives the DRAM for one cycle, WAIT counts out the DRAM read latency.
// Ports:
//   clk  - system clock (divided core clock)
//   rst  - asynchronous reset, active high
//   bus  - dram_arbiter_if.slave: cpu_*/dma_* request ports, dram_* bus,
//          busy/owner status. All outputs are registered.
// Parameter:
//   READ_LAT - cycles from address issue to valid dram_dout (1..7)
module dram_arbiter #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dram_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             grant;      // a request is captured this cycle
  logic             grant_dma;  // ... and it belongs to the DMA port
  logic             latch;      // read data is valid on dram_dout this cycle
  logic             rr_dma;     // priority pointer: 1 favours DMA
  logic             cap_we;     // captured request type
  logic [CNT_W-1:0] cnt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and grant decision; the pointer only matters when both request
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_dma = 1'b0;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          grant     = 1'b1;
          grant_dma = bus.dma_req && (!bus.cpu_req || rr_dma);
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = cap_we ? IDLE : WAIT;
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          latch     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture, DRAM-side and requester-side registers.
  // dram_addr/dram_din double as the captured address/data, so they hold the
  // last issued values through WAIT and IDLE without extra storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_dma         <= 1'b0;
      cap_we         <= 1'b0;
      cnt            <= '0;
      bus.owner      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.dram_we    <= 1'b0;
      bus.dram_addr  <= '0;
      bus.dram_din   <= '0;
      bus.cpu_ack    <= 1'b0;
      bus.dma_ack    <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.dma_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.dma_rdata  <= '0;
    end else begin
      // single-cycle pulses default low
      bus.dram_we    <= 1'b0;
      bus.cpu_ack    <= 1'b0;
      bus.dma_ack    <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.dma_rvalid <= 1'b0;
      bus.busy       <= (state_nxt != IDLE);

      // registering the grant places ack and dram_we exactly in ISSUE
      if (grant) begin
        rr_dma        <= !grant_dma;
        bus.owner     <= grant_dma;
        cap_we        <= grant_dma ? bus.dma_we    : bus.cpu_we;
        bus.dram_we   <= grant_dma ? bus.dma_we    : bus.cpu_we;
        bus.dram_addr <= grant_dma ? bus.dma_addr  : bus.cpu_addr;
        bus.dram_din  <= grant_dma ? bus.dma_wdata : bus.cpu_wdata;
        bus.cpu_ack   <= !grant_dma;
        bus.dma_ack   <= grant_dma;
      end

      // latency counter: loaded in ISSUE, counts down through WAIT
      if (state == ISSUE) begin
        cnt <= CNT_W'(READ_LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end

      // only the grantee's rdata changes; rvalid lands in the following IDLE
      if (latch) begin
        if (bus.owner) begin
          bus.dma_rdata  <= bus.dram_dout;
          bus.dma_rvalid <= 1'b1;
        end else begin
          bus.cpu_rdata  <= bus.dram_dout;
          bus.cpu_rvalid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// Purpose: scoreboard bench for dram_arbiter. Drivers push each presented
// transaction into a per-port queue; a negedge monitor predicts grants,
// DRAM-bus values, busy and read returns from cycle arithmetic and a
// reference memory, then compares against the DUT.
module tb_dram_arbiter;
  localparam int unsigned LAT      = 3;
  localparam int unsigned MEM_SIZE = 131072;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
    int         due;
  } rd_t;

  logic clk = 1'b0;
  logic rst;

  dram_arbiter_if bus();

  dram_arbiter #(.READ_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // initial DRAM contents; 0x00010 preset to 0xC3
  function automatic logic [7:0] init_val(input logic [16:0] a);
    if (a == 17'h00010) return 8'hC3;
    return 8'(a * 17'd7) ^ 8'(a >> 9);
  endfunction

  // DRAM model: data for the address issued in cycle N appears in cycle N+LAT
  bit   [7:0] mem   [MEM_SIZE];
  bit         mem_w [MEM_SIZE];
  logic [7:0] pipe  [LAT];

  always @(posedge clk) begin
    if (bus.dram_we) begin
      mem[bus.dram_addr]   <= bus.dram_din;
      mem_w[bus.dram_addr] <= 1'b1;
    end
    pipe[0] <= mem_w[bus.dram_addr] ? mem[bus.dram_addr] : init_val(bus.dram_addr);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.dram_dout = pipe[LAT-1];

  // reference memory, updated in grant order from the bench's own transactions
  bit [7:0] ref_mem [MEM_SIZE];
  bit       ref_w   [MEM_SIZE];

  function automatic logic [7:0] ref_rd(input logic [16:0] a);
    return ref_w[a] ? ref_mem[a] : init_val(a);
  endfunction

  txn_t cpu_q[$];
  txn_t dma_q[$];
  rd_t  rdq[$];

  // monitor / reference model state
  int          c          = 0;
  int          idle_from  = 0;
  bit          fav_dma    = 1'b0;
  bit          own_exp    = 1'b0;
  bit          prev_cpu   = 1'b0;
  bit          prev_dma   = 1'b0;
  logic [16:0] exp_addr   = '0;
  logic [7:0]  exp_din    = '0;
  logic [7:0]  cpu_rd_exp = '0;
  logic [7:0]  dma_rd_exp = '0;

  initial begin
    txn_t t;
    rd_t  r;
    int   g;
    forever begin
      @(negedge clk);
      c++;
      if (rst) begin
        chk("reset_outputs",
            64'({bus.cpu_ack, bus.cpu_rvalid, bus.cpu_rdata, bus.dma_ack, bus.dma_rvalid,
                 bus.dma_rdata, bus.dram_addr, bus.dram_we, bus.dram_din, bus.busy, bus.owner}),
            64'd0);
        cpu_q.delete();
        dma_q.delete();
        rdq.delete();
        idle_from  = c + 1;
        fav_dma    = 1'b0;
        own_exp    = 1'b0;
        exp_addr   = '0;
        exp_din    = '0;
        cpu_rd_exp = '0;
        dma_rd_exp = '0;
        prev_cpu   = 1'b0;
        prev_dma   = 1'b0;
      end else begin
        // a request seen in a free cycle is issued in the next cycle
        if ((c - 1 >= idle_from) && (prev_cpu || prev_dma)) begin
          g = (prev_cpu && prev_dma) ? (fav_dma ? 1 : 0) : (prev_dma ? 1 : 0);
          chk("pending_txn", 64'((g == 0) ? (cpu_q.size() > 0) : (dma_q.size() > 0)), 64'd1);
          t = '0;
          if (g == 0 && cpu_q.size() > 0) t = cpu_q.pop_front();
          if (g == 1 && dma_q.size() > 0) t = dma_q.pop_front();
          chk("cpu_ack", 64'(bus.cpu_ack), 64'(g == 0));
          chk("dma_ack", 64'(bus.dma_ack), 64'(g == 1));
          chk("issue_we", 64'(bus.dram_we), 64'(t.we));
          exp_addr = t.addr;
          exp_din  = t.wdata;
          own_exp  = (g == 1);
          fav_dma  = (g == 0);
          if (t.we) begin
            ref_mem[t.addr] = t.wdata;
            ref_w[t.addr]   = 1'b1;
            idle_from       = c + 1;
          end else begin
            r.port = (g == 1);
            r.data = ref_rd(t.addr);
            r.due  = c + LAT + 1;
            rdq.push_back(r);
            idle_from = c + LAT + 1;
          end
        end else if (bus.cpu_ack || bus.dma_ack || bus.dram_we) begin
          chk("idle_ack_we", 64'({bus.cpu_ack, bus.dma_ack, bus.dram_we}), 64'd0);
        end

        chk("dram_addr", 64'(bus.dram_addr), 64'(exp_addr));
        chk("dram_din", 64'(bus.dram_din), 64'(exp_din));
        chk("owner", 64'(bus.owner), 64'(own_exp));
        chk("busy", 64'(bus.busy), 64'(c < idle_from));

        if (rdq.size() > 0 && rdq[0].due == c) begin
          r = rdq.pop_front();
          chk("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(r.port == 1'b0));
          chk("dma_rvalid", 64'(bus.dma_rvalid), 64'(r.port == 1'b1));
          if (r.port) dma_rd_exp = r.data;
          else        cpu_rd_exp = r.data;
        end else if (bus.cpu_rvalid || bus.dma_rvalid) begin
          chk("stray_rvalid", 64'({bus.cpu_rvalid, bus.dma_rvalid}), 64'd0);
        end

        chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(cpu_rd_exp));
        chk("dma_rdata", 64'(bus.dma_rdata), 64'(dma_rd_exp));

        prev_cpu = bus.cpu_req;
        prev_dma = bus.dma_req;
      end
    end
  end

  // Present one transaction on port p (0 CPU, 1 DMA) and wait for its ack.
  // Called at posedge+1; returns at posedge+1 of the ack cycle.
  task automatic issue(input int p, input bit we, input logic [16:0] a,
                       input logic [7:0] d, input bit hold, output int ncyc);
    txn_t t;
    bit   got;
    t.we = we; t.addr = a; t.wdata = d;
    got  = 1'b0;
    ncyc = 0;
    if (p == 0) begin
      cpu_q.push_back(t);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end else begin
      dma_q.push_back(t);
      bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
    end
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if ((p == 0) ? bus.cpu_ack : bus.dma_ack) begin
        got  = 1'b1;
        ncyc = i + 1;
        break;
      end
    end
    chk("ack_within_bound", 64'(got), 64'd1);
    if (!hold) begin
      if (p == 0) bus.cpu_req = 1'b0;
      else        bus.dma_req = 1'b0;
    end
  endtask

  task automatic port_traffic(input int p, input int n);
    bit          we;
    bit          hold;
    logic [16:0] a;
    int          gap;
    int          nc;
    for (int k = 0; k < n; k++) begin
      we   = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 3) == 0) ? 17'($urandom) : 17'($urandom_range(0, 15));
      hold = ($urandom_range(0, 3) == 0);
      issue(p, we, a, 8'($urandom), hold, nc);
      if (!hold) begin
        gap = $urandom_range(0, 3);
        for (int j = 0; j < gap; j++) begin
          @(posedge clk);
          #1;
        end
      end
    end
    if (p == 0) bus.cpu_req = 1'b0;
    else        bus.dma_req = 1'b0;
  endtask

  task automatic wait_rvalid(input int p, output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if ((p == 0) ? bus.cpu_rvalid : bus.dma_rvalid) begin
        k = i;
        break;
      end
      chk("wait_addr_stable", 64'(bus.dram_addr), 64'(exp_addr));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    int n2;
    int k;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // CPU write, DMA idle
    issue(0, 1'b1, 17'h1ABCD, 8'h5A, 1'b0, n1);
    chk("wr_ack_cycle", 64'(n1), 64'd1);
    chk("wr_dram_we", 64'(bus.dram_we), 64'd1);
    chk("wr_dram_addr", 64'(bus.dram_addr), 64'h1ABCD);
    chk("wr_dram_din", 64'(bus.dram_din), 64'h5A);
    @(posedge clk);
    #1;
    chk("wr_we_one_cycle", 64'(bus.dram_we), 64'd0);

    // CPU read of preset location
    issue(0, 1'b0, 17'h00010, 8'h00, 1'b0, n1);
    wait_rvalid(0, k);
    chk("cpu_rd_latency", 64'(k), 64'(LAT + 1));
    chk("cpu_rd_data", 64'(bus.cpu_rdata), 64'hC3);

    // DMA read: latency and address held through WAIT
    issue(1, 1'b0, 17'h0ABCD, 8'h3C, 1'b0, n1);
    wait_rvalid(1, k);
    chk("dma_rd_latency", 64'(k), 64'(LAT + 1));
    chk("dma_rd_data", 64'(bus.dma_rdata), 64'(init_val(17'h0ABCD)));

    // req held after ack becomes a second access
    issue(0, 1'b1, 17'h00020, 8'h77, 1'b1, n1);
    issue(0, 1'b1, 17'h00021, 8'h78, 1'b0, n2);
    chk("held_req_second_ack", 64'(n2), 64'd2);

    // randomized concurrent traffic
    fork
      port_traffic(0, 80);
      port_traffic(1, 80);
    join
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("reads_drained", 64'(rdq.size()), 64'd0);

    // reset while a CPU read is in WAIT
    issue(0, 1'b0, 17'h00010, 8'h00, 1'b0, n1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_wait_outputs",
        64'({bus.cpu_ack, bus.cpu_rvalid, bus.cpu_rdata, bus.dma_ack, bus.dma_rvalid,
             bus.dma_rdata, bus.dram_addr, bus.dram_we, bus.dram_din, bus.busy, bus.owner}),
        64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;

    // simultaneous writes after reset: CPU first, then strict alternation
    fork
      begin
        issue(0, 1'b1, 17'h00100, 8'h11, 1'b1, n1);
        issue(0, 1'b1, 17'h00101, 8'h12, 1'b1, k);
        issue(0, 1'b1, 17'h00102, 8'h13, 1'b0, k);
      end
      begin
        issue(1, 1'b1, 17'h00200, 8'h21, 1'b1, n2);
        issue(1, 1'b1, 17'h00201, 8'h22, 1'b1, k);
        issue(1, 1'b1, 17'h00202, 8'h23, 1'b0, k);
      end
    join
    chk("rr_cpu_first", 64'(n1 < n2), 64'd1);

    // asynchronous drop of dram_we
    issue(0, 1'b1, 17'h0F0F0, 8'hAA, 1'b0, n1);
    chk("async_we_before", 64'(bus.dram_we), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_we_drop", 64'(bus.dram_we), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1, 1'b1, 17'h00300, 8'h44, 1'b0, n1);
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
